// File: rtl/apb_master.sv
// apb_master: APB3/APB4 initiator that runs one SETUP->ACCESS transfer per bridge request, with a PREADY timeout
//   ACLK/ARESETn             clock and synchronous active-low reset
//   transfer/read/write      request strobes; write wins when read and write are both set
//   req_strb/apb_waddr/apb_raddr/apb_wdata   request payload, sampled only in IDLE
//   apb_rdata/err_flag/apb_done              completion back to the bridge (err_flag valid with apb_done)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB   registered APB request
//   PREADY/PRDATA/PSLVERR                    APB completion, sampled only in ACCESS with PREADY=1
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int TO_WIDTH   = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    transfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [ADDR_WIDTH-1:0]   apb_waddr,
  input  logic [ADDR_WIDTH-1:0]   apb_raddr,
  input  logic [DATA_WIDTH-1:0]   apb_wdata,
  output logic [DATA_WIDTH-1:0]   apb_rdata,
  output logic                    err_flag,
  output logic                    apb_done,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam logic [TO_WIDTH-1:0] TO_LIM = TO_WIDTH'(TIMEOUT);
  state_t state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic done_q, done_d, err_q, err_d;
  logic start, to_hit, finish;
  assign start   = transfer & (read | write);
  assign cnt_inc = cnt_q + TO_WIDTH'(1);
  // abort on the ACCESS edge whose wait cycle would bring the count to TIMEOUT
  assign to_hit  = (TIMEOUT != 0) && !PREADY && (cnt_inc == TO_LIM);
  assign finish  = PREADY | to_hit;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = finish ? DONE : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cnt_d     = '0;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = write;
        paddr_d   = write ? apb_waddr : apb_raddr;
        pwdata_d  = write ? apb_wdata : '0;
        pstrb_d   = write ? req_strb : '0;
      end
      SETUP: penable_d = 1'b1;
      ACCESS: if (finish) begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        done_d    = 1'b1;
        err_d     = PREADY ? PSLVERR : 1'b1;
        rdata_d   = pwrite_q ? rdata_q : (PREADY ? PRDATA : '0);
      end else begin
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end
  assign apb_rdata = rdata_q;
  assign err_flag  = err_q;
  assign apb_done  = done_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven check of apb_master transfers plus timeout and reset sequences
module tb_apb_master;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic transfer = 0, read = 0, write = 0, PREADY = 0, PSLVERR = 0;
  logic [3:0] req_strb = 0;
  logic [31:0] apb_waddr = 0, apb_raddr = 0, apb_wdata = 0, PRDATA = 0;
  logic [31:0] apb_rdata, PADDR, PWDATA, apb_rdata_1, PADDR_1, PWDATA_1;
  logic err_flag, apb_done, PSEL, PENABLE, PWRITE;
  logic err_flag_1, apb_done_1, PSEL_1, PENABLE_1, PWRITE_1;
  logic [3:0] PSTRB, PSTRB_1;
  int total = 0, bad = 0;
  always #5 ACLK = ~ACLK;
  apb_master #(.TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .transfer(transfer), .read(read), .write(write),
    .req_strb(req_strb), .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata), .err_flag(err_flag), .apb_done(apb_done), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR));
  apb_master #(.TIMEOUT(0)) dut_nt (
    .ACLK(ACLK), .ARESETn(ARESETn), .transfer(transfer), .read(read), .write(write),
    .req_strb(req_strb), .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata_1), .err_flag(err_flag_1), .apb_done(apb_done_1), .PADDR(PADDR_1), .PSEL(PSEL_1),
    .PENABLE(PENABLE_1), .PWRITE(PWRITE_1), .PWDATA(PWDATA_1), .PSTRB(PSTRB_1), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR));
  typedef struct {
    logic tr, rd, wr;
    logic [31:0] waddr, raddr, wdata;
    logic [3:0] strb;
    int waits;
    logic [31:0] prdata;
    logic slverr;
    logic e_pwrite;
    logic [31:0] e_paddr, e_pwdata;
    logic [3:0] e_pstrb;
    int e_done, e_psel, e_pen;
    logic e_err;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  // Request is applied before edge N; iteration c samples the state after edge N+c.
  task automatic run_vec(input vec_t t, input string nm);
    int done_edge = -1, np = 0, ne = 0, nd = 0, held_bad = 0, lim;
    logic [31:0] sa = 0, sd = 0, r_at = 0;
    logic [3:0] ss = 0;
    logic sw = 0, e_at = 0;
    lim = (t.e_done < 0) ? 6 : t.e_done + 2;
    transfer = t.tr; read = t.rd; write = t.wr;
    apb_waddr = t.waddr; apb_raddr = t.raddr; apb_wdata = t.wdata; req_strb = t.strb;
    PRDATA = t.prdata; PSLVERR = t.slverr; PREADY = 0;
    for (int c = 0; c < lim; c++) begin
      @(posedge ACLK); @(negedge ACLK);
      if (c == 0) begin transfer = 0; read = 0; write = 0; end
      PREADY = (c + 1 >= t.waits + 2);
      if (PSEL) np++;
      if (PENABLE) ne++;
      if (PENABLE && !PSEL) held_bad++;
      if (PSEL && !PENABLE) begin sa = PADDR; sw = PWRITE; sd = PWDATA; ss = PSTRB; end
      else if (PSEL && {PADDR, PWRITE, PWDATA, PSTRB} != {sa, sw, sd, ss}) held_bad++;
      if (apb_done) begin
        nd++;
        if (done_edge < 0) begin done_edge = c; e_at = err_flag; r_at = apb_rdata; end
      end
    end
    PREADY = 0;
    chk({nm, "_done_edge"}, done_edge, t.e_done);
    chk({nm, "_done_cycles"}, nd, (t.e_done < 0) ? 0 : 1);
    chk({nm, "_psel_cycles"}, np, t.e_psel);
    chk({nm, "_penable_cycles"}, ne, t.e_pen);
    chk({nm, "_stable"}, held_bad, 0);
    chk({nm, "_idle_after"}, {PSEL, PENABLE, apb_done, err_flag}, 0);
    chk({nm, "_rdata_final"}, apb_rdata, t.e_rdata);
    if (t.e_done >= 0) begin
      chk({nm, "_paddr"}, sa, t.e_paddr);
      chk({nm, "_pwrite"}, sw, t.e_pwrite);
      chk({nm, "_pwdata"}, sd, t.e_pwdata);
      chk({nm, "_pstrb"}, ss, t.e_pstrb);
      chk({nm, "_err"}, e_at, t.e_err);
      chk({nm, "_rdata_at_done"}, r_at, t.e_rdata);
    end
  endtask
  initial begin
    int to_edge, nt_done;
    v[0] = '{1,0,1, 32'h1000, 32'h0, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0,
             1, 32'h1000, 32'hDEADBEEF, 4'hF, 2, 2, 1, 0, 32'h0};
    v[1] = '{1,1,0, 32'h5555, 32'h2004, 32'h11111111, 4'hA, 2, 32'hCAFEF00D, 0,
             0, 32'h2004, 32'h0, 4'h0, 4, 4, 3, 0, 32'hCAFEF00D};
    v[2] = '{1,0,1, 32'h3000, 32'h0, 32'h12345678, 4'h3, 1, 32'h0BADBEEF, 1,
             1, 32'h3000, 32'h12345678, 4'h3, 3, 3, 2, 1, 32'hCAFEF00D};
    v[3] = '{1,1,1, 32'h4000, 32'h4444, 32'hA5A5A5A5, 4'h5, 0, 32'h0, 0,
             1, 32'h4000, 32'hA5A5A5A5, 4'h5, 2, 2, 1, 0, 32'hCAFEF00D};
    v[4] = '{0,0,1, 32'h6000, 32'h0, 32'h1, 4'hF, 0, 32'h0, 0,
             0, 32'h0, 32'h0, 4'h0, -1, 0, 0, 0, 32'hCAFEF00D};
    v[5] = '{1,0,0, 32'h7000, 32'h7004, 32'h0, 4'h0, 0, 32'h0, 0,
             0, 32'h0, 32'h0, 4'h0, -1, 0, 0, 0, 32'hCAFEF00D};
    v[6] = '{1,1,0, 32'h0, 32'h10, 32'h0, 4'h0, 0, 32'h77, 1,
             0, 32'h10, 32'h0, 4'h0, 2, 2, 1, 1, 32'h77};
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_state", |{PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, apb_rdata, err_flag, apb_done}, 0);
    ARESETn = 1;
    for (int i = 0; i < 7; i++) run_vec(v[i], $sformatf("v%0d", i));
    // timeout: PREADY never rises; the TIMEOUT=16 instance aborts on the 16th ACCESS edge
    to_edge = -1; nt_done = 0;
    transfer = 1; read = 1; write = 0; apb_raddr = 32'h2008; PRDATA = 32'hFFFFFFFF; PSLVERR = 0; PREADY = 0;
    for (int c = 0; c < 110; c++) begin
      @(posedge ACLK); @(negedge ACLK);
      if (c == 0) begin transfer = 0; read = 0; end
      if (apb_done && to_edge < 0) begin
        to_edge = c;
        chk("to_err", err_flag, 1);
        chk("to_rdata", apb_rdata, 0);
        chk("to_psel_pen", {PSEL, PENABLE}, 0);
      end
      if (apb_done_1) nt_done++;
    end
    chk("to_done_edge", to_edge, 17);
    chk("no_to_done", nt_done, 0);
    chk("no_to_still_access", {PSEL_1, PENABLE_1}, 2'b11);
    // reset while the TIMEOUT=0 instance sits in ACCESS
    ARESETn = 0;
    @(posedge ACLK); @(negedge ACLK);
    ARESETn = 1;
    chk("rst_mid_zero", |{PSEL_1, PENABLE_1, PWRITE_1, PADDR_1, PWDATA_1, PSTRB_1, apb_rdata_1, err_flag_1, apb_done_1}, 0);
    nt_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge ACLK); @(negedge ACLK);
      if (apb_done_1 || PSEL_1) nt_done++;
    end
    chk("rst_mid_quiet", nt_done, 0);
    run_vec(v[0], "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
